// File: rtl/io_periph_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_periph_pkg
// Description : Shared register map and data width for the IO peripheral block.
// Revision    : 1.0 - initial release
// ============================================================================
package io_periph_pkg;

   localparam int unsigned IO_DATA_W    = 8;

   localparam int unsigned ADDR_KEYS     = 0;
   localparam int unsigned ADDR_SWITCHES = 1;
   localparam int unsigned ADDR_LEDS     = 2;
   localparam int unsigned ADDR_PEND_KEY = 3;
   localparam int unsigned ADDR_PEND_SW  = 4;
   localparam int unsigned ADDR_MASK_KEY = 5;
   localparam int unsigned ADDR_MASK_SW  = 6;

endpackage
`default_nettype wire

// File: rtl/io_periph_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module      : io_debounce
// Description : Two-flop synchroniser plus stable-count debouncer with edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module io_debounce #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter bit INVERT          = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

   logic               r_sync1;
   logic               r_sync2;
   logic               r_stable;
   logic               r_rise;
   logic               r_fall;
   logic [c_cnt_w-1:0] r_cnt;
   logic               w_mismatch;
   logic               w_accept;

   assign w_mismatch = (r_sync2 != r_stable);
   assign w_accept   = w_mismatch && (r_cnt == c_cnt_last);

   // Any cycle where the synced level agrees with the stable level restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= raw ^ INVERT;
         r_sync2 <= r_sync1;
         r_rise  <= w_accept & r_sync2;
         r_fall  <= w_accept & ~r_sync2;
         if (w_accept) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else if (w_mismatch) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign stable = r_stable;
   assign rise   = r_rise;
   assign fall   = r_fall;

endmodule
`default_nettype wire

// File: rtl/io_periph_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : io_periph_ctrl
// Description : Memory-mapped keys/switches/LEDs controller with debounced
//               inputs, sticky W1C pending, mask and registered interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module io_periph_ctrl
   import io_periph_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int NUM_SWITCHES    = 4,
   parameter int NUM_LEDS        = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int ADDR_WIDTH      = 5
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [ADDR_WIDTH-1:0]          readaddr,
   output logic [7:0]                     readdata,
   input  logic [ADDR_WIDTH-1:0]          writeaddr,
   input  logic [7:0]                     writedata,
   input  logic                           write_en,
   input  logic [NUM_KEYS-1:0]            keys,
   input  logic [NUM_SWITCHES-1:0]        switches,
   output logic [NUM_LEDS-1:0]            leds,
   output logic [NUM_KEYS+NUM_SWITCHES-1:0] interrupts,
   output logic                           irq_any
);

   logic [NUM_KEYS-1:0]              w_key_stable, w_key_rise, w_key_fall;
   logic [NUM_SWITCHES-1:0]          w_sw_stable, w_sw_rise, w_sw_fall;
   logic [NUM_KEYS-1:0]              r_pend_key, r_mask_key, w_w1c_key, w_pend_key_next;
   logic [NUM_SWITCHES-1:0]          r_pend_sw, r_mask_sw, w_w1c_sw, w_pend_sw_next;
   logic [NUM_LEDS-1:0]              r_leds;
   logic [NUM_KEYS+NUM_SWITCHES-1:0] r_interrupts, w_irq_next;
   logic                             r_irq_any;
   logic [IO_DATA_W-1:0]             r_readdata, w_rd;
   logic                             w_unused;

   // Key pins are active-low; inverting at the synchroniser makes pressed read as 1.
   generate
      for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
         io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INVERT(1'b1)) u_deb (
            .clk(clk), .reset(reset), .raw(keys[i]),
            .stable(w_key_stable[i]), .rise(w_key_rise[i]), .fall(w_key_fall[i])
         );
      end
      for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
         io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INVERT(1'b0)) u_deb (
            .clk(clk), .reset(reset), .raw(switches[i]),
            .stable(w_sw_stable[i]), .rise(w_sw_rise[i]), .fall(w_sw_fall[i])
         );
      end
   endgenerate

   assign w_w1c_key = (write_en && writeaddr == ADDR_WIDTH'(ADDR_PEND_KEY))
                    ? writedata[NUM_KEYS-1:0] : '0;
   assign w_w1c_sw  = (write_en && writeaddr == ADDR_WIDTH'(ADDR_PEND_SW))
                    ? writedata[NUM_SWITCHES-1:0] : '0;

   // Event set is OR-ed after the clear so a same-cycle event wins over W1C.
   assign w_pend_key_next = (r_pend_key & ~w_w1c_key) | w_key_rise;
   assign w_pend_sw_next  = (r_pend_sw & ~w_w1c_sw) | w_sw_rise | w_sw_fall;
   assign w_irq_next      = {r_pend_sw & r_mask_sw, r_pend_key & r_mask_key};

   always_comb begin
      w_rd = '0;
      case (readaddr)
         ADDR_WIDTH'(ADDR_KEYS):     w_rd = IO_DATA_W'(w_key_stable);
         ADDR_WIDTH'(ADDR_SWITCHES): w_rd = IO_DATA_W'(w_sw_stable);
         ADDR_WIDTH'(ADDR_LEDS):     w_rd = IO_DATA_W'(r_leds);
         ADDR_WIDTH'(ADDR_PEND_KEY): w_rd = IO_DATA_W'(r_pend_key);
         ADDR_WIDTH'(ADDR_PEND_SW):  w_rd = IO_DATA_W'(r_pend_sw);
         ADDR_WIDTH'(ADDR_MASK_KEY): w_rd = IO_DATA_W'(r_mask_key);
         ADDR_WIDTH'(ADDR_MASK_SW):  w_rd = IO_DATA_W'(r_mask_sw);
         default:                    w_rd = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_leds       <= '0;
         r_pend_key   <= '0;
         r_pend_sw    <= '0;
         r_mask_key   <= '0;
         r_mask_sw    <= '0;
         r_interrupts <= '0;
         r_irq_any    <= 1'b0;
         r_readdata   <= '0;
      end else begin
         r_pend_key   <= w_pend_key_next;
         r_pend_sw    <= w_pend_sw_next;
         r_interrupts <= w_irq_next;
         r_irq_any    <= |w_irq_next;
         r_readdata   <= w_rd;
         if (write_en && writeaddr == ADDR_WIDTH'(ADDR_LEDS))
            r_leds <= writedata[NUM_LEDS-1:0];
         if (write_en && writeaddr == ADDR_WIDTH'(ADDR_MASK_KEY))
            r_mask_key <= writedata[NUM_KEYS-1:0];
         if (write_en && writeaddr == ADDR_WIDTH'(ADDR_MASK_SW))
            r_mask_sw <= writedata[NUM_SWITCHES-1:0];
      end
   end

   // Key releases raise no event, and data bits above each field are don't-care.
   assign w_unused = ^{w_key_fall, writedata};

   assign readdata   = r_readdata;
   assign leds       = r_leds;
   assign interrupts = r_interrupts;
   assign irq_any    = r_irq_any;

endmodule
`default_nettype wire

// File: tb/tb_io_periph_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_periph_ctrl
// Description : Self-checking bench for io_periph_ctrl (4 keys/switches/LEDs, 4-cycle debounce).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_periph_ctrl;

   localparam int NK = 4;
   localparam int NS = 4;
   localparam int NL = 4;
   localparam int DB = 4;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] readaddr, writeaddr;
   logic [7:0]    readdata, writedata;
   logic          write_en;
   logic [NK-1:0] keys;
   logic [NS-1:0] switches;
   logic [NL-1:0] leds;
   logic [NK+NS-1:0] interrupts;
   logic          irq_any;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_v;

   io_periph_ctrl #(
      .NUM_KEYS(NK), .NUM_SWITCHES(NS), .NUM_LEDS(NL),
      .DEBOUNCE_CYCLES(DB), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .reset(reset),
      .readaddr(readaddr), .readdata(readdata),
      .writeaddr(writeaddr), .writedata(writedata), .write_en(write_en),
      .keys(keys), .switches(switches), .leds(leds),
      .interrupts(interrupts), .irq_any(irq_any)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
      writeaddr = a;
      writedata = d;
      write_en  = 1'b1;
      tick();
      write_en  = 1'b0;
   endtask

   // Queue the expected read value, then present the address for one edge.
   task automatic issue_read(input logic [AW-1:0] a, input logic [7:0] e);
      readaddr = a;
      exp_q.push_back(e);
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; keys = '1; switches = '0; write_en = 1'b0;
      readaddr = '0; writeaddr = '0; writedata = '0;
      ticks(3);
      checks++; if (readdata !== 8'h00) begin errors++; $display("FAIL reset_readdata: got %h want 00", readdata); end
      checks++; if (leds !== 4'h0) begin errors++; $display("FAIL reset_leds: got %h want 0", leds); end
      checks++; if (interrupts !== 8'h00) begin errors++; $display("FAIL reset_interrupts: got %h want 00", interrupts); end
      checks++; if (irq_any !== 1'b0) begin errors++; $display("FAIL reset_irq_any: got %b want 0", irq_any); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_leds();
      do_write(5'd2, 8'hA5);
      checks++; if (leds !== 4'h5) begin errors++; $display("FAIL led_write: got %h want 5", leds); end
      issue_read(5'd2, 8'h05);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL led_readback: got %h want %h", readdata, exp_v); end
      // Same-address read and write in one cycle returns the old value.
      readaddr = 5'd2; writeaddr = 5'd2; writedata = 8'h03; write_en = 1'b1;
      exp_q.push_back(8'h05);
      tick();
      write_en = 1'b0;
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL rw_collision: got %h want %h", readdata, exp_v); end
      issue_read(5'd2, 8'h03);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL led_readback2: got %h want %h", readdata, exp_v); end
      do_write(5'd0, 8'hFF);
      issue_read(5'd0, 8'h00);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL ro_write_ignored: got %h want %h", readdata, exp_v); end
      do_write(5'd9, 8'hFF);
      issue_read(5'd9, 8'h00);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL unmapped_read: got %h want %h", readdata, exp_v); end
   endtask

   task automatic test_debounce();
      // One cycle short of acceptance: must be rejected.
      keys[0] = 1'b0;
      ticks(3);
      keys[0] = 1'b1;
      ticks(10);
      issue_read(5'd0, 8'h00);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL glitch_keys: got %h want %h", readdata, exp_v); end
      issue_read(5'd3, 8'h00);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL glitch_pend: got %h want %h", readdata, exp_v); end
      // Stable flips on the 6th edge after the pin change; readdata shows it one edge later.
      readaddr = 5'd0;
      keys[0] = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         exp_q.push_back((k >= 7) ? 8'h01 : 8'h00);
         tick();
         exp_v = exp_q.pop_front();
         checks++; if (readdata !== exp_v) begin errors++; $display("FAIL debounce_latency cyc%0d: got %h want %h", k, readdata, exp_v); end
      end
      issue_read(5'd3, 8'h01);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL press_pend: got %h want %h", readdata, exp_v); end
   endtask

   task automatic test_mask_irq();
      checks++; if (interrupts !== 8'h00) begin errors++; $display("FAIL masked_irq: got %h want 00", interrupts); end
      do_write(5'd5, 8'h01);
      checks++; if (interrupts !== 8'h00) begin errors++; $display("FAIL unmask_early: got %h want 00", interrupts); end
      tick();
      checks++; if (interrupts !== 8'h01) begin errors++; $display("FAIL unmask_irq: got %h want 01", interrupts); end
      checks++; if (irq_any !== 1'b1) begin errors++; $display("FAIL unmask_any: got %b want 1", irq_any); end
      do_write(5'd3, 8'h01);
      checks++; if (interrupts !== 8'h01) begin errors++; $display("FAIL w1c_early: got %h want 01", interrupts); end
      tick();
      checks++; if (interrupts !== 8'h00) begin errors++; $display("FAIL w1c_irq: got %h want 00", interrupts); end
      checks++; if (irq_any !== 1'b0) begin errors++; $display("FAIL w1c_any: got %b want 0", irq_any); end
      keys[0] = 1'b1;
      ticks(10);
      issue_read(5'd3, 8'h00);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL release_pend: got %h want %h", readdata, exp_v); end
      issue_read(5'd0, 8'h00);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL release_keys: got %h want %h", readdata, exp_v); end
   endtask

   task automatic test_collision();
      // Event pulse is live during the 7th edge after the pin change; W1C lands on that edge.
      switches[2] = 1'b1;
      ticks(6);
      do_write(5'd4, 8'h04);
      issue_read(5'd4, 8'h04);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL set_wins: got %h want %h", readdata, exp_v); end
      checks++; if (interrupts !== 8'h00) begin errors++; $display("FAIL sw_masked: got %h want 00", interrupts); end
      do_write(5'd4, 8'h04);
      issue_read(5'd4, 8'h00);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL sw_w1c: got %h want %h", readdata, exp_v); end
   endtask

   task automatic test_switch_edges();
      switches[1] = 1'b1;
      ticks(10);
      issue_read(5'd4, 8'h02);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL sw_rise_pend: got %h want %h", readdata, exp_v); end
      issue_read(5'd1, 8'h06);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL sw_state_hi: got %h want %h", readdata, exp_v); end
      do_write(5'd4, 8'h02);
      issue_read(5'd4, 8'h00);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL sw_clear: got %h want %h", readdata, exp_v); end
      switches[1] = 1'b0;
      ticks(10);
      issue_read(5'd4, 8'h02);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL sw_fall_pend: got %h want %h", readdata, exp_v); end
      issue_read(5'd1, 8'h04);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL sw_state_lo: got %h want %h", readdata, exp_v); end
      do_write(5'd4, 8'h02);
   endtask

   task automatic test_reset_mid();
      do_write(5'd2, 8'hFF);
      keys[1] = 1'b0;
      ticks(10);
      do_write(5'd5, 8'h02);
      tick();
      checks++; if (interrupts !== 8'h02) begin errors++; $display("FAIL pre_reset_irq: got %h want 02", interrupts); end
      // Key3 counter reaches 2 after four edges, then reset abandons it.
      keys[3] = 1'b0;
      ticks(4);
      reset = 1'b1;
      keys[3] = 1'b1;
      tick();
      checks++; if (leds !== 4'h0) begin errors++; $display("FAIL mid_reset_leds: got %h want 0", leds); end
      checks++; if (interrupts !== 8'h00) begin errors++; $display("FAIL mid_reset_irq: got %h want 00", interrupts); end
      checks++; if (irq_any !== 1'b0) begin errors++; $display("FAIL mid_reset_any: got %b want 0", irq_any); end
      checks++; if (readdata !== 8'h00) begin errors++; $display("FAIL mid_reset_rd: got %h want 00", readdata); end
      reset = 1'b0;
      readaddr = 5'd3;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(8'h00);
         tick();
         exp_v = exp_q.pop_front();
         checks++; if (readdata !== exp_v) begin errors++; $display("FAIL post_reset_pend cyc%0d: got %h want %h", k, readdata, exp_v); end
      end
      ticks(10);
      issue_read(5'd3, 8'h02);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL redebounce_key: got %h want %h", readdata, exp_v); end
      issue_read(5'd4, 8'h04);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL redebounce_sw: got %h want %h", readdata, exp_v); end
      issue_read(5'd0, 8'h02);
      exp_v = exp_q.pop_front();
      checks++; if (readdata !== exp_v) begin errors++; $display("FAIL post_reset_keys: got %h want %h", readdata, exp_v); end
      checks++; if (interrupts !== 8'h00) begin errors++; $display("FAIL post_reset_masked: got %h want 00", interrupts); end
   endtask

   initial begin
      test_reset();
      test_leds();
      test_debounce();
      test_mask_irq();
      test_collision();
      test_switch_edges();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
